// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the SRAM memory controller.
package arm_mem_pkg;

    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;

    // CPU byte address that maps onto SRAM word 0
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Access sequencer states: idle, low half-word, high half-word, completion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: counts cycles spent in one half-access phase and
// flags the final cycle of that phase.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [3:0] cnt_q;

    // Cleared on every phase entry; saturates at the terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else if (clear) begin
            cnt_q <= 4'd0;
        end else if (enable && !tc) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Terminal count marks the last cycle of the current phase
    always_comb begin
        tc = (cnt_q == 4'(WAIT_CYCLES - 1));
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// 32-bit CPU load/store port onto a 16-bit asynchronous SRAM.
// Each access is split into a low and a high half-word phase of WAIT_CYCLES
// cycles each, followed by a single DONE cycle in which ready is raised.
// Optional: define SRAM_ACCESS_CNT_EN to add rd_count/wr_count access counters.
module sram_mem_ctrl
    import arm_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
`ifdef SRAM_ACCESS_CNT_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    sram_state_t state_q, state_d;

    logic        req;
    logic        tc;
    logic        in_acc;
    logic        half;
    logic        cnt_clear;
    logic [16:0] off_word;

    // Request latched at access start; later input changes are ignored
    logic        is_wr_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;

    // Low half is staged so read_data only changes when a read completes
    logic [15:0] lo_q;
    logic [31:0] rdata_q;

    // Request decode and SRAM word offset of the CPU address
    always_comb begin
        req      = rd_en | wr_en;
        off_word = 17'((address - BASE_ADDR) >> 2);
        in_acc   = (state_q == LOW) || (state_q == HIGH);
        half     = (state_q == HIGH);
    end

    // Next-state logic; DONE always returns to IDLE for one request gap
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = LOW;
            LOW:     if (tc)  state_d = HIGH;
            HIGH:    if (tc)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_clear = (state_d != state_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch request type, word address and store data at access start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_wr_q <= 1'b0;
            word_q  <= 17'd0;
            wdata_q <= 32'd0;
        end else if (state_q == IDLE && req) begin
            is_wr_q <= wr_en;
            word_q  <= off_word;
            wdata_q <= write_data;
        end
    end

    // Capture pad data on the last cycle of each read phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q    <= 16'd0;
            rdata_q <= 32'd0;
        end else if (!is_wr_q && tc) begin
            if (state_q == LOW) begin
                lo_q <= sram_dq_in;
            end else if (state_q == HIGH) begin
                rdata_q <= {sram_dq_in, lo_q};
            end
        end
    end

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .enable(in_acc),
        .tc    (tc)
    );

    // SRAM pins and CPU handshake; strobe released on each phase's last cycle
    always_comb begin
        sram_addr   = in_acc ? {word_q, half} : '0;
        sram_dq_oe  = in_acc && is_wr_q && !tc;
        sram_we_n   = !(in_acc && is_wr_q && !tc);
        sram_dq_out = '0;
        if (in_acc && is_wr_q) begin
            sram_dq_out = half ? wdata_q[31:16] : wdata_q[15:0];
        end
        ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
        read_data = rdata_q;
    end

`ifdef SRAM_ACCESS_CNT_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Count completed accesses by type; free-running wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (state_q == DONE) begin
            if (is_wr_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    // Counter outputs
    always_comb begin
        rd_count = rd_cnt_q;
        wr_count = wr_cnt_q;
    end
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl (WAIT_CYCLES=4, BASE_ADDR=1024).
// Build with SRAM_ACCESS_CNT_EN defined to also check the access counters.
module tb_sram_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
`ifdef SRAM_ACCESS_CNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    int total = 0;
    int bad   = 0;
    int exp_rd_cnt = 0;
    int exp_wr_cnt = 0;

    sram_mem_ctrl #(
        .WAIT_CYCLES(4),
        .BASE_ADDR  (32'd1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
`ifdef SRAM_ACCESS_CNT_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small SRAM model: 64 half-words, aliased on the low address bits
    logic [15:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_a  = 6'd0;
    logic [15:0] pre_d  = 16'd0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr[5:0]];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] base;      // expected sram_addr during LOW
        logic [31:0] exp_rdata; // expected read_data in DONE
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic check_idle_pins(input string tag);
        chk({tag, "_we_n"}, sram_we_n, 1'b1);
        chk({tag, "_oe"}, sram_dq_oe, 1'b0);
        chk({tag, "_addr"}, sram_addr, 18'd0);
    endtask

    // One full access: request in cycle 0, phases in cycles 1..8, DONE in 9
    task automatic run_txn(input vec_t v);
        logic half;
        logic last;
        @(negedge clk);
        rd_en      = v.rd;
        wr_en      = v.wr;
        address    = v.addr;
        write_data = v.wdata;
        #1;
        chk("ready_req", ready, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble inputs: the access must use the latched values
                rd_en      = 1'b0;
                wr_en      = 1'b0;
                address    = 32'hFFFF_FFF0;
                write_data = 32'h5A5A_5A5A;
            end
            #1;
            half = (c > 4);
            last = (c == 4) || (c == 8);
            chk("ready_busy", ready, 1'b0);
            chk("sram_addr", sram_addr, v.base | {17'd0, half});
            chk("we_n", sram_we_n, !(v.wr && !last));
            chk("dq_oe", sram_dq_oe, v.wr && !last);
            if (v.wr) chk("dq_out", sram_dq_out, half ? v.wdata[31:16] : v.wdata[15:0]);
        end
        @(negedge clk);
        #1;
        chk("ready_done", ready, 1'b1);
        chk("read_data", read_data, v.exp_rdata);
        check_idle_pins("done");
        if (v.wr) exp_wr_cnt++;
        else exp_rd_cnt++;
    endtask

    initial begin
        int first_rdy;
        int second_rdy;
        int busy_cycles;

        // rd, wr, address, wdata, sram base, expected read_data
        vecs[0] = '{1'b0, 1'b1, 32'd1024,   32'hDEAD_BEEF, 18'd0,       32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'd1028,   32'h0,         18'd2,       32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'd1032,   32'hCAFE_F00D, 18'd4,       32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'd1024,   32'h0,         18'd0,       32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b0, 32'd1032,   32'h0,         18'd4,       32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b1, 32'd1027,   32'h0BAD_F00D, 18'd0,       32'hCAFE_F00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1024,   32'h0,         18'd0,       32'h0BAD_F00D};
        vecs[7] = '{1'b0, 1'b1, 32'd1020,   32'h1357_9BDF, 18'h3FFFE,   32'h0BAD_F00D};
        vecs[8] = '{1'b1, 1'b0, 32'd525308, 32'h0,         18'h3FFFE,   32'h1357_9BDF};

        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        #2;
        chk("rst_ready", ready, 1'b1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_dq_out", sram_dq_out, 16'd0);
        check_idle_pins("rst");

        preload(6'd2, 16'h5678);
        preload(6'd3, 16'h1234);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_ready", ready, 1'b1);

        foreach (vecs[i]) run_txn(vecs[i]);

`ifdef SRAM_ACCESS_CNT_EN
        @(negedge clk);
        #1;
        chk("rd_count_tbl", rd_count, exp_rd_cnt);
        chk("wr_count_tbl", wr_count, exp_wr_cnt);
`endif

        // Reset in the 3rd cycle of HIGH during a write
        @(negedge clk);
        wr_en      = 1'b1;
        address    = 32'd1024;
        write_data = 32'h1111_2222;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) wr_en = 1'b0;
        end
        #1;
        chk("pre_abort_we_n", sram_we_n, 1'b0);
        rst = 1'b0;
        #1;
        check_idle_pins("abort");
        chk("abort_ready", ready, 1'b1);
        chk("abort_read_data", read_data, 32'd0);
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("post_rst_ready", ready, 1'b1);
            chk("post_rst_we_n", sram_we_n, 1'b1);
        end

        // Back-to-back reads with rd_en held
        @(negedge clk);
        rd_en       = 1'b1;
        address     = 32'd1028;
        first_rdy   = -1;
        second_rdy  = -1;
        busy_cycles = 0;
        #1;
        for (int c = 0; c < 40 && second_rdy < 0; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (!ready) busy_cycles++;
            else if (first_rdy < 0) first_rdy = c;
            else begin
                second_rdy = c;
                rd_en      = 1'b0;
            end
        end
        rd_en = 1'b0;
        chk("b2b_first_ready", first_rdy, 9);
        chk("b2b_second_ready", second_rdy, 19);
        chk("b2b_busy_cycles", busy_cycles, 18);
        chk("b2b_read_data", read_data, 32'h1234_5678);
        @(negedge clk);
        #1;
        chk("b2b_idle_ready", ready, 1'b1);
`ifdef SRAM_ACCESS_CNT_EN
        chk("b2b_rd_count", rd_count, 32'd2);
        chk("b2b_wr_count", wr_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
